// File: rtl/conway_serial_grid.sv
`default_nettype none
// ============================================================================
// Module : conway_serial_grid
// Serially loaded Game-of-Life grid with burst-mode generation stepping.
// Rev    : 1.0
// ============================================================================
module conway_serial_grid #(
    parameter int GRID_WIDTH    = 8,
    parameter int GRID_HEIGHT   = 8,
    parameter int GEN_CNT_WIDTH = 8,
    parameter int WRAP          = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic [1:0]               mode,
    input  logic                     start,
    input  logic [GEN_CNT_WIDTH-1:0] gen_req,
    output logic                     data_out,
    output logic                     busy,
    output logic                     done,
    output logic                     extinct,
    output logic                     stable,
    output logic [GEN_CNT_WIDTH-1:0] gen_count
);
    localparam int N  = GRID_WIDTH * GRID_HEIGHT;
    localparam int PW = GRID_WIDTH + 2;
    localparam int PH = GRID_HEIGHT + 2;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_OUT  = 2'b10;

    localparam logic [GEN_CNT_WIDTH-1:0] GEN_ONE = {{(GEN_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GEN_CNT_WIDTH-1:0] GEN_MAX = {GEN_CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             grid_q, grid_d, grid_next;
    logic [GEN_CNT_WIDTH-1:0] gen_count_q, gen_count_d;
    logic [GEN_CNT_WIDTH-1:0] gen_req_q, gen_req_d;
    logic [GEN_CNT_WIDTH-1:0] gen_inc;
    logic                     stable_q, stable_d;
    logic                     extinct_q, extinct_d;
    logic [PH*PW-1:0]         padded;

    // Grid framed by a one-cell border: dead cells, or the opposite edge when wrapping.
    for (genvar pr = 0; pr < PH; pr++) begin : g_prow
        for (genvar pc = 0; pc < PW; pc++) begin : g_pcol
            localparam int SR = (pr == 0) ? GRID_HEIGHT - 1 : (pr == PH - 1) ? 0 : pr - 1;
            localparam int SC = (pc == 0) ? GRID_WIDTH - 1  : (pc == PW - 1) ? 0 : pc - 1;
            localparam bit ON_EDGE = (pr == 0) || (pr == PH - 1) || (pc == 0) || (pc == PW - 1);
            if (ON_EDGE && (WRAP == 0)) begin : g_dead
                assign padded[pr*PW+pc] = 1'b0;
            end else begin : g_src
                assign padded[pr*PW+pc] = grid_q[SR*GRID_WIDTH+SC];
            end
        end
    end

    for (genvar r = 0; r < GRID_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < GRID_WIDTH; c++) begin : g_col
            localparam int P = r * PW + c;
            logic [3:0] nbr;
            assign nbr = {3'b000, padded[P]}        + {3'b000, padded[P+1]}      +
                         {3'b000, padded[P+2]}      + {3'b000, padded[P+PW]}     +
                         {3'b000, padded[P+PW+2]}   + {3'b000, padded[P+2*PW]}   +
                         {3'b000, padded[P+2*PW+1]} + {3'b000, padded[P+2*PW+2]};
            assign grid_next[r*GRID_WIDTH+c] =
                (nbr == 4'd3) || (grid_q[r*GRID_WIDTH+c] && (nbr == 4'd2));
        end
    end

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        gen_count_d = gen_count_q;
        gen_req_d   = gen_req_q;
        stable_d    = stable_q;
        extinct_d   = ~|grid_q;
        gen_inc     = (gen_count_q == GEN_MAX) ? gen_count_q : gen_count_q + GEN_ONE;

        case (mode)
            MODE_LOAD: begin
                grid_d   = {data_in, grid_q[N-1:1]};
                stable_d = 1'b0;
            end
            MODE_OUT: grid_d = {grid_q[0], grid_q[N-1:1]};
            default:  ;
        endcase

        case (state_q)
            IDLE: begin
                if (start && (mode == MODE_RUN)) begin
                    gen_req_d   = gen_req;
                    gen_count_d = '0;
                    state_d     = (gen_req == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                // Leaving run mode abandons the burst silently with the last result kept.
                if (mode != MODE_RUN) begin
                    state_d = IDLE;
                end else begin
                    grid_d      = grid_next;
                    gen_count_d = gen_inc;
                    stable_d    = (grid_next == grid_q);
                    if ((gen_inc == gen_req_q) || (grid_next == '0) || (grid_next == grid_q)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grid_q      <= '0;
            gen_count_q <= '0;
            gen_req_q   <= '0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            gen_count_q <= gen_count_d;
            gen_req_q   <= gen_req_d;
            stable_q    <= stable_d;
            extinct_q   <= extinct_d;
        end
    end

    assign data_out  = grid_q[0];
    assign busy      = (state_q == RUN);
    assign done      = (state_q == FINISH);
    assign extinct   = extinct_q;
    assign stable    = stable_q;
    assign gen_count = gen_count_q;

endmodule
`default_nettype wire

// File: tb/tb_conway_serial_grid.sv
`default_nettype none
// ============================================================================
// Module : tb_conway_serial_grid
// Randomised self-checking bench with a coordinate-level Life reference model.
// Rev    : 1.0
// ============================================================================
module tb_conway_serial_grid;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         reset, data_in, start;
    logic [1:0]   mode;
    logic [7:0]   gen_req;
    logic         data_out0, busy0, done0, extinct0, stable0;
    logic         data_out1, busy1, done1, extinct1, stable1;
    logic [7:0]   gen_count0, gen_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conway_serial_grid #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_CNT_WIDTH(8), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .start(start),
        .gen_req(gen_req), .data_out(data_out0), .busy(busy0), .done(done0),
        .extinct(extinct0), .stable(stable0), .gen_count(gen_count0));

    conway_serial_grid #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_CNT_WIDTH(8), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .start(start),
        .gen_req(gen_req), .data_out(data_out1), .busy(busy1), .done(done1),
        .extinct(extinct1), .stable(stable1), .gen_count(gen_count1));

    // Reference: Life rule applied by row/column coordinates.
    function automatic logic [N-1:0] life_step(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] nx;
        int cnt, rr, cc;
        nx = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                        end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                            continue;
                        end
                        cnt += int'(g[rr*W+cc]);
                    end
                end
                nx[r*W+c] = (cnt == 3) || (g[r*W+c] && cnt == 2);
            end
        end
        return nx;
    endfunction

    task automatic model_burst(input logic [N-1:0] g0, input int req, input bit wrap,
                               output logic [N-1:0] gf, output int steps, output bit stab);
        logic [N-1:0] nx;
        gf    = g0;
        steps = 0;
        stab  = 1'b0;
        while (steps < req) begin
            nx    = life_step(gf, wrap);
            stab  = (nx == gf);
            gf    = nx;
            steps = steps + 1;
            if (nx == '0 || stab) break;
        end
    endtask

    task automatic load_grid(input logic [N-1:0] p);
        mode = 2'b00;
        for (int i = 0; i < N; i++) begin
            data_in = p[i];
            @(negedge clk);
        end
        data_in = 1'b0;
        mode    = 2'b11;
    endtask

    task automatic read_grid(output logic [N-1:0] s0, output logic [N-1:0] s1);
        mode = 2'b10;
        for (int i = 0; i < N; i++) begin
            s0[i] = data_out0;
            s1[i] = data_out1;
            @(negedge clk);
        end
        mode = 2'b11;
    endtask

    task automatic do_burst(input int req, input int window, input int req_later, input bit restart,
                            output int dn0, output int bz0, output int dn1, output int bz1);
        dn0 = 0; bz0 = 0; dn1 = 0; bz1 = 0;
        mode    = 2'b01;
        gen_req = 8'(req);
        start   = 1'b1;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            dn0 += int'(done0); bz0 += int'(busy0);
            dn1 += int'(done1); bz1 += int'(busy1);
            start = (i == 0) ? restart : 1'b0;
            if (i == 0) gen_req = 8'(req_later);
        end
        start = 1'b0;
        mode  = 2'b11;
    endtask

    task automatic test_reset();
        logic [N-1:0] s0, s1;
        mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            data_in = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++; if (data_out0 !== 1'b0) begin errors++; $display("FAIL reset_data_out got %b expected 0", data_out0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done0); end
        checks++; if (stable0 !== 1'b0) begin errors++; $display("FAIL reset_stable got %b expected 0", stable0); end
        checks++; if (gen_count0 !== 8'd0) begin errors++; $display("FAIL reset_gen_count got %0d expected 0", gen_count0); end
        checks++; if (extinct0 !== 1'b1) begin errors++; $display("FAIL reset_extinct got %b expected 1", extinct0); end
        @(negedge clk);
        reset   = 1'b1;
        data_in = 1'b0;
        mode    = 2'b11;
        @(negedge clk);
        read_grid(s0, s1);
        checks++; if (s0 !== '0) begin errors++; $display("FAIL reset_grid got %h expected 0", s0); end
    endtask

    task automatic test_gen_req_zero();
        logic [N-1:0] p, s0, s1;
        int dn0, bz0, dn1, bz1;
        p = {$urandom, $urandom};
        load_grid(p);
        do_burst(0, 4, 0, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL zero_done got %0d expected 1", dn0); end
        checks++; if (bz0 !== 0) begin errors++; $display("FAIL zero_busy got %0d expected 0", bz0); end
        checks++; if (gen_count0 !== 8'd0) begin errors++; $display("FAIL zero_gen_count got %0d expected 0", gen_count0); end
        read_grid(s0, s1);
        checks++; if (s0 !== p) begin errors++; $display("FAIL zero_grid got %h expected %h", s0, p); end
    endtask

    task automatic test_load_readout();
        logic [N-1:0] p, a0, a1, b0, b1;
        p = {$urandom, $urandom};
        load_grid(p);
        @(negedge clk);
        checks++; if (stable0 !== 1'b0) begin errors++; $display("FAIL load_stable got %b expected 0", stable0); end
        checks++; if (extinct0 !== (p == '0)) begin errors++; $display("FAIL load_extinct got %b expected %b", extinct0, p == '0); end
        read_grid(a0, a1);
        read_grid(b0, b1);
        checks++; if (a0 !== p) begin errors++; $display("FAIL readout_first got %h expected %h", a0, p); end
        checks++; if (b0 !== p) begin errors++; $display("FAIL readout_second got %h expected %h", b0, p); end
        checks++; if (b1 !== p) begin errors++; $display("FAIL readout_wrapdut got %h expected %h", b1, p); end
    endtask

    task automatic test_blinker();
        logic [N-1:0] p, e, s0, s1;
        int dn0, bz0, dn1, bz1;
        p = '0; p[25] = 1'b1; p[26] = 1'b1; p[27] = 1'b1;
        e = '0; e[18] = 1'b1; e[26] = 1'b1; e[34] = 1'b1;
        load_grid(p);
        do_burst(1, 5, 1, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL blinker_done got %0d expected 1", dn0); end
        checks++; if (gen_count0 !== 8'd1) begin errors++; $display("FAIL blinker_gen_count got %0d expected 1", gen_count0); end
        checks++; if (stable0 !== 1'b0) begin errors++; $display("FAIL blinker_stable got %b expected 0", stable0); end
        read_grid(s0, s1);
        checks++; if (s0 !== e) begin errors++; $display("FAIL blinker_grid got %h expected %h", s0, e); end
    endtask

    task automatic test_block();
        logic [N-1:0] p, s0, s1;
        int dn0, bz0, dn1, bz1;
        p = '0; p[0] = 1'b1; p[1] = 1'b1; p[8] = 1'b1; p[9] = 1'b1;
        load_grid(p);
        do_burst(10, 14, 10, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL block_done got %0d expected 1", dn0); end
        checks++; if (gen_count0 !== 8'd1) begin errors++; $display("FAIL block_gen_count got %0d expected 1", gen_count0); end
        checks++; if (stable0 !== 1'b1) begin errors++; $display("FAIL block_stable got %b expected 1", stable0); end
        read_grid(s0, s1);
        checks++; if (s0 !== p) begin errors++; $display("FAIL block_grid got %h expected %h", s0, p); end
    endtask

    task automatic test_single();
        logic [N-1:0] p;
        int dn0, bz0, dn1, bz1;
        p = '0; p[36] = 1'b1;
        load_grid(p);
        do_burst(5, 9, 5, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL single_done got %0d expected 1", dn0); end
        checks++; if (gen_count0 !== 8'd1) begin errors++; $display("FAIL single_gen_count got %0d expected 1", gen_count0); end
        checks++; if (extinct0 !== 1'b1) begin errors++; $display("FAIL single_extinct got %b expected 1", extinct0); end
    endtask

    task automatic test_glider();
        logic [N-1:0] p, gf, s0, s1;
        int dn0, bz0, dn1, bz1, steps;
        bit stab;
        p = '0; p[1] = 1'b1; p[10] = 1'b1; p[16] = 1'b1; p[17] = 1'b1; p[18] = 1'b1;
        load_grid(p);
        do_burst(32, 40, 32, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn1 !== 1) begin errors++; $display("FAIL glider_done got %0d expected 1", dn1); end
        checks++; if (gen_count1 !== 8'd32) begin errors++; $display("FAIL glider_gen_count got %0d expected 32", gen_count1); end
        checks++; if (stable1 !== 1'b0) begin errors++; $display("FAIL glider_stable got %b expected 0", stable1); end
        model_burst(p, 32, 1'b0, gf, steps, stab);
        checks++; if (gen_count0 !== 8'(steps)) begin errors++; $display("FAIL glider_edge_count got %0d expected %0d", gen_count0, steps); end
        read_grid(s0, s1);
        checks++; if (s1 !== p) begin errors++; $display("FAIL glider_grid got %h expected %h", s1, p); end
        checks++; if (s0 !== gf) begin errors++; $display("FAIL glider_edge_grid got %h expected %h", s0, gf); end
    endtask

    task automatic test_back_to_back_random();
        logic [N-1:0] p, gf0, gf1, s0, s1;
        int dn0, bz0, dn1, bz1, st0, st1, req;
        bit sb0, sb1;
        for (int k = 0; k < 8; k++) begin
            p   = ({$urandom, $urandom} & {$urandom, $urandom}) | ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            req = $urandom_range(0, 6);
            model_burst(p, req, 1'b0, gf0, st0, sb0);
            model_burst(p, req, 1'b1, gf1, st1, sb1);
            load_grid(p);
            do_burst(req, req + 3, req, 1'b0, dn0, bz0, dn1, bz1);
            checks++; if (dn0 !== 1 || dn1 !== 1) begin errors++; $display("FAIL rand%0d_done got %0d/%0d expected 1/1", k, dn0, dn1); end
            checks++; if (bz0 !== st0 || bz1 !== st1) begin errors++; $display("FAIL rand%0d_busy got %0d/%0d expected %0d/%0d", k, bz0, bz1, st0, st1); end
            checks++; if (gen_count0 !== 8'(st0) || gen_count1 !== 8'(st1)) begin errors++; $display("FAIL rand%0d_gen_count got %0d/%0d expected %0d/%0d", k, gen_count0, gen_count1, st0, st1); end
            checks++; if (stable0 !== sb0 || stable1 !== sb1) begin errors++; $display("FAIL rand%0d_stable got %b/%b expected %b/%b", k, stable0, stable1, sb0, sb1); end
            checks++; if (extinct0 !== (gf0 == '0) || extinct1 !== (gf1 == '0)) begin errors++; $display("FAIL rand%0d_extinct got %b/%b expected %b/%b", k, extinct0, extinct1, gf0 == '0, gf1 == '0); end
            read_grid(s0, s1);
            checks++; if (s0 !== gf0) begin errors++; $display("FAIL rand%0d_grid_nowrap got %h expected %h", k, s0, gf0); end
            checks++; if (s1 !== gf1) begin errors++; $display("FAIL rand%0d_grid_wrap got %h expected %h", k, s1, gf1); end
        end
    endtask

    task automatic test_sample_gen_req();
        logic [N-1:0] p, s0, s1;
        int dn0, bz0, dn1, bz1;
        p = '0; p[25] = 1'b1; p[26] = 1'b1; p[27] = 1'b1;
        load_grid(p);
        mode = 2'b11; start = 1'b1; gen_req = 8'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL ignored_start got busy %b done %b expected 0 0", busy0, done0); end
        do_burst(4, 8, 1, 1'b1, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL sampled_done got %0d expected 1", dn0); end
        checks++; if (gen_count0 !== 8'd4) begin errors++; $display("FAIL sampled_gen_count got %0d expected 4", gen_count0); end
        read_grid(s0, s1);
        checks++; if (s0 !== p) begin errors++; $display("FAIL sampled_grid got %h expected %h", s0, p); end
    endtask

    task automatic test_abort();
        logic [N-1:0] p, gf0, gf1, s0, s1;
        int dn, steps;
        bit stab, hit;
        p = '0; p[1] = 1'b1; p[10] = 1'b1; p[16] = 1'b1; p[17] = 1'b1; p[18] = 1'b1;
        load_grid(p);
        dn = 0; hit = 1'b0;
        mode = 2'b01; gen_req = 8'd10; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            dn += int'(done0);
            if (busy0 && gen_count0 == 8'd3) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach got gen_count %0d expected 3", gen_count0); end
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dn += int'(done0);
        end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy0); end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done got %0d expected 0", dn); end
        checks++; if (gen_count0 !== 8'd3) begin errors++; $display("FAIL abort_gen_count got %0d expected 3", gen_count0); end
        model_burst(p, 3, 1'b0, gf0, steps, stab);
        model_burst(p, 3, 1'b1, gf1, steps, stab);
        read_grid(s0, s1);
        checks++; if (s0 !== gf0) begin errors++; $display("FAIL abort_grid got %h expected %h", s0, gf0); end
        checks++; if (s1 !== gf1) begin errors++; $display("FAIL abort_grid_wrap got %h expected %h", s1, gf1); end
    endtask

    task automatic test_reset_midburst();
        logic [N-1:0] p, s0, s1;
        int dn;
        bit hit;
        p = '0; p[1] = 1'b1; p[10] = 1'b1; p[16] = 1'b1; p[17] = 1'b1; p[18] = 1'b1;
        load_grid(p);
        dn = 0; hit = 1'b0;
        mode = 2'b01; gen_req = 8'd10; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy0 && gen_count0 == 8'd3) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_reach got gen_count %0d expected 3", gen_count0); end
        reset = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0 || gen_count0 !== 8'd0) begin errors++; $display("FAIL midreset_state got busy %b count %0d expected 0 0", busy0, gen_count0); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dn += int'(done0) + int'(done1);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL midreset_done got %0d expected 0", dn); end
        checks++; if (extinct0 !== 1'b1) begin errors++; $display("FAIL midreset_extinct got %b expected 1", extinct0); end
        mode = 2'b11;
        read_grid(s0, s1);
        checks++; if (s0 !== '0 || s1 !== '0) begin errors++; $display("FAIL midreset_grid got %h/%h expected 0", s0, s1); end
    endtask

    task automatic test_long_burst();
        logic [N-1:0] p, gf, s0, s1;
        int dn0, bz0, dn1, bz1, steps;
        bit stab;
        p = '0; p[25] = 1'b1; p[26] = 1'b1; p[27] = 1'b1;
        model_burst(p, 255, 1'b0, gf, steps, stab);
        load_grid(p);
        do_burst(255, 259, 255, 1'b0, dn0, bz0, dn1, bz1);
        checks++; if (dn0 !== 1) begin errors++; $display("FAIL long_done got %0d expected 1", dn0); end
        checks++; if (gen_count0 !== 8'(steps)) begin errors++; $display("FAIL long_gen_count got %0d expected %0d", gen_count0, steps); end
        read_grid(s0, s1);
        checks++; if (s0 !== gf) begin errors++; $display("FAIL long_grid got %h expected %h", s0, gf); end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        start   = 1'b0;
        mode    = 2'b11;
        gen_req = 8'd0;
        @(negedge clk);
        test_reset();
        test_gen_req_zero();
        test_load_readout();
        test_blinker();
        test_block();
        test_single();
        test_glider();
        test_back_to_back_random();
        test_sample_gen_req();
        test_abort();
        test_reset_midburst();
        test_long_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
